if_stage: RTL and testbench

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_stage.sv | 133 +++++++++++++
 tb/tb_if_stage.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// if_stage: instruction fetch stage with a combinational instruction ROM,
// a PC redirect mux and an optional two-phase "double-issue" sequencer.
// Optional feature: define IF_STAGE_DOUBLE_EN to build the double-issue FSM;
// without it the stage always fetches sequentially and the second-phase
// flags stay low.
module if_stage #(
    parameter int          MEM_DEPTH   = 256,
    parameter logic [5:0]  DOUBLE_OP_A = 6'd6,
    parameter logic [5:0]  DOUBLE_OP_B = 6'd7
) (
    input  logic        clk,
    input  logic        clear,
    input  logic        stall,
    input  logic        kill,
    input  logic        turn_off,
    input  logic [1:0]  pc_src,
    input  logic [31:0] branch,
    input  logic [31:0] jr,
    input  logic [31:0] jump,
    output logic [5:0]  d_opcode,
    output logic [3:0]  d_rd,
    output logic [31:0] inst_buff_data,
    output logic [31:0] pc_buff_tun,
    output logic        add_rd,
    output logic        add_imm
);

    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic [31:0] pc_plus_one;
    logic [31:0] pc_seq;
    logic [31:0] pc_buff_tun_q;
    logic [31:0] pc_buff_tun_d;
    logic [31:0] mem_word;
    logic        add_pc;

    // Fixed program image; words beyond the image (or beyond MEM_DEPTH) read zero.
    function automatic logic [31:0] rom_word(input logic [7:0] addr);
        logic [31:0] word;
        word = 32'h0000_0000;
        if (int'(addr) < MEM_DEPTH) begin
            case (addr)
                8'd0:    word = 32'h1444_0005;
                8'd1:    word = 32'h1C40_0001;
                8'd2:    word = 32'h1400_0001;
                8'd3:    word = 32'h28CC_FFFD;
                default: word = 32'h0000_0000;
            endcase
        end
        return word;
    endfunction

    // Read the instruction at the low PC byte and split out decode fields.
    always_comb begin
        mem_word       = rom_word(pc_q[7:0]);
        d_opcode       = mem_word[31:26];
        d_rd           = mem_word[25:22];
        inst_buff_data = kill ? 32'h0000_0000 : mem_word;
    end

`ifdef IF_STAGE_DOUBLE_EN
    localparam logic [0:0] ST_FIRST  = 1'b0;
    localparam logic [0:0] ST_SECOND = 1'b1;

    logic [0:0] state_q;
    logic [0:0] state_d;
    logic       is_double;
    logic       start_double;

    // A double opcode seen in FIRST holds the PC one cycle and enters SECOND.
    always_comb begin
        is_double    = (d_opcode == DOUBLE_OP_A) || (d_opcode == DOUBLE_OP_B);
        start_double = (state_q == ST_FIRST) && !kill && (pc_src == 2'd0) && is_double;
        add_pc       = !start_double;
        add_rd       = (state_q == ST_SECOND);
        add_imm      = (state_q == ST_SECOND);
        state_d      = state_q;
        if (!stall) begin
            state_d = start_double ? ST_SECOND : ST_FIRST;
        end
    end

    // Double-issue state register.
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            state_q <= ST_FIRST;
        end else begin
            state_q <= state_d;
        end
    end
`else
    logic [11:0] unused_double_ops;
    assign unused_double_ops = {DOUBLE_OP_A, DOUBLE_OP_B};

    // Without the sequencer every fetch advances and no second phase exists.
    always_comb begin
        add_pc  = 1'b1;
        add_rd  = 1'b0;
        add_imm = 1'b0;
    end
`endif

    // Next-PC selection: any redirect wins over the sequential candidate.
    always_comb begin
        pc_plus_one   = pc_q + 32'd1;
        pc_seq        = add_pc ? pc_plus_one : pc_q;
        pc_d          = pc_seq;
        case (pc_src)
            2'd0:    pc_d = pc_seq;
            2'd1:    pc_d = branch;
            2'd2:    pc_d = jr;
            default: pc_d = jump;
        endcase
        if (stall) begin
            pc_d = pc_q;
        end
        pc_buff_tun_d = turn_off ? pc_buff_tun_q : pc_plus_one;
    end

    // PC and the PC+1 buffer register toward decode.
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            pc_q          <= 32'h0000_0000;
            pc_buff_tun_q <= 32'h0000_0000;
        end else begin
            pc_q          <= pc_d;
            pc_buff_tun_q <= pc_buff_tun_d;
        end
    end

    assign pc_buff_tun = pc_buff_tun_q;

endmodule

// File: tb/tb_if_stage.sv
// Testbench for if_stage: directed stimulus, a behavioural reference model
// checked every cycle, plus hand-computed literal expectations.
module tb_if_stage;

   logic        clk;
   logic        clear;
   logic        stall;
   logic        kill;
   logic        turnOff;
   logic [1:0]  pcSrc;
   logic [31:0] branchAddr;
   logic [31:0] jrAddr;
   logic [31:0] jumpAddr;
   logic [5:0]  dOpcode;
   logic [3:0]  dRd;
   logic [31:0] instData;
   logic [31:0] pcBuffTun;
   logic        addRd;
   logic        addImm;

   int passCount  = 0;
   int checkCount = 0;
   bit started    = 0;

`ifdef IF_STAGE_DOUBLE_EN
   localparam bit DoubleEn = 1'b1;
`else
   localparam bit DoubleEn = 1'b0;
`endif

   if_stage dut (
      .clk            (clk),
      .clear          (clear),
      .stall          (stall),
      .kill           (kill),
      .turn_off       (turnOff),
      .pc_src         (pcSrc),
      .branch         (branchAddr),
      .jr             (jrAddr),
      .jump           (jumpAddr),
      .d_opcode       (dOpcode),
      .d_rd           (dRd),
      .inst_buff_data (instData),
      .pc_buff_tun    (pcBuffTun),
      .add_rd         (addRd),
      .add_imm        (addImm)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference program image, indexed by PC modulo 256.
   logic [31:0] modelMem [256];
   initial begin
      for (int i = 0; i < 256; i++) modelMem[i] = 32'h0;
      modelMem[0] = 32'h1444_0005;
      modelMem[1] = 32'h1C40_0001;
      modelMem[2] = 32'h1400_0001;
      modelMem[3] = 32'h28CC_FFFD;
   end

   // Model state: the PC, whether we sit in the second phase of a double
   // instruction, and the last captured PC+1.
   logic [31:0] modelPc;
   bit          modelSecond;
   logic [31:0] modelPcbt;

   function automatic logic [31:0] wordAt(input logic [31:0] pc);
      return modelMem[pc % 256];
   endfunction

   // Model advance: a double opcode first seen without kill/redirect repeats
   // its fetch once; everything else follows the redirect or steps by one.
   always @(posedge clk or negedge clear) begin
      if (!clear) begin
         modelPc     = 32'h0;
         modelSecond = 1'b0;
         modelPcbt   = 32'h0;
      end else begin
         logic [5:0] op;
         bit repeatFetch;
         op = wordAt(modelPc) >> 26;
         repeatFetch = DoubleEn && !modelSecond && !kill && pcSrc == 2'd0 &&
                       (op == 6'd6 || op == 6'd7);
         if (!turnOff) modelPcbt = modelPc + 32'd1;
         if (!stall) begin
            if (pcSrc == 2'd1)      modelPc = branchAddr;
            else if (pcSrc == 2'd2) modelPc = jrAddr;
            else if (pcSrc == 2'd3) modelPc = jumpAddr;
            else if (!repeatFetch)  modelPc = modelPc + 32'd1;
            modelSecond = repeatFetch;
         end
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checkCount++;
      if (actual === expected) passCount++;
      else $display("[TB] FAIL %s actual=0x%08h expected=0x%08h at %0t",
                    name, actual, expected, $time);
   endtask

   // Every cycle, compare all outputs against the model away from the edge.
   always @(negedge clk) begin
      if (started) begin
         logic [31:0] w;
         w = wordAt(modelPc);
         checkOutput("model inst",     instData,           kill ? 32'h0 : w);
         checkOutput("model opcode",   32'(dOpcode),       32'(w[31:26]));
         checkOutput("model rd",       32'(dRd),           32'(w[25:22]));
         checkOutput("model pcbt",     pcBuffTun,          modelPcbt);
         checkOutput("model add_rd",   32'(addRd),         32'(modelSecond));
         checkOutput("model add_imm",  32'(addImm),        32'(modelSecond));
      end
   end

   task automatic applyStimulus(input logic s, input logic k, input logic t,
                                input logic [1:0] src);
      #1;
      stall   = s;
      kill    = k;
      turnOff = t;
      pcSrc   = src;
   endtask

   // Directed sequence with literal expectations worked out by hand.
   initial begin
      clear = 1'b0; stall = 1'b0; kill = 1'b0; turnOff = 1'b0; pcSrc = 2'd0;
      branchAddr = 32'd2; jrAddr = 32'd3; jumpAddr = 32'd4;
      #3;
      checkOutput("reset inst",   instData,        32'h1444_0005);
      checkOutput("reset opcode", 32'(dOpcode),    32'd5);
      checkOutput("reset rd",     32'(dRd),        32'd1);
      checkOutput("reset add_rd", 32'(addRd),      32'd0);
      checkOutput("reset pcbt",   pcBuffTun,       32'd0);
      started = 1'b1;
      @(negedge clk); #1; clear = 1'b1;

      // Three idle edges from reset.
      @(negedge clk);
      checkOutput("seq1 opcode", 32'(dOpcode), 32'd7);
      checkOutput("seq1 pcbt",   pcBuffTun,    32'd1);
      checkOutput("seq1 add_rd", 32'(addRd),   32'd0);
      @(negedge clk);
      checkOutput("seq2 pcbt",   pcBuffTun,    32'd2);
`ifdef IF_STAGE_DOUBLE_EN
      checkOutput("seq2 opcode",  32'(dOpcode), 32'd7);
      checkOutput("seq2 add_rd",  32'(addRd),   32'd1);
      checkOutput("seq2 add_imm", 32'(addImm),  32'd1);
      @(negedge clk);
      checkOutput("seq3 opcode", 32'(dOpcode), 32'd5);
      checkOutput("seq3 add_rd", 32'(addRd),   32'd0);
      checkOutput("seq3 pcbt",   pcBuffTun,    32'd2);
`else
      checkOutput("seq2 opcode", 32'(dOpcode), 32'd5);
      checkOutput("seq2 add_rd", 32'(addRd),   32'd0);
      @(negedge clk);
      checkOutput("seq3 opcode", 32'(dOpcode), 32'd10);
      checkOutput("seq3 pcbt",   pcBuffTun,    32'd3);
`endif

      // Redirects: branch=2, jr=3, jump=4.
      applyStimulus(0, 0, 0, 2'd1); @(negedge clk);
      checkOutput("branch opcode", 32'(dOpcode), 32'd5);
      checkOutput("branch rd",     32'(dRd),     32'd0);
      applyStimulus(0, 0, 0, 2'd2); @(negedge clk);
      checkOutput("jr opcode", 32'(dOpcode), 32'd10);
      checkOutput("jr rd",     32'(dRd),     32'd3);
      applyStimulus(0, 0, 0, 2'd3); @(negedge clk);
      checkOutput("jump inst", instData, 32'h0);

      // Kill at PC=2 masks only the buffered word.
      applyStimulus(0, 0, 0, 2'd1); @(negedge clk);
      applyStimulus(0, 1, 0, 2'd0); #1;
      checkOutput("kill inst",   instData,     32'h0);
      checkOutput("kill opcode", 32'(dOpcode), 32'd5);
      checkOutput("kill rd",     32'(dRd),     32'd0);
      @(negedge clk);

      // Kill on a double opcode: no PC hold.
      jumpAddr = 32'd1;
      applyStimulus(0, 0, 0, 2'd3); @(negedge clk);
      checkOutput("jump1 opcode", 32'(dOpcode), 32'd7);
      applyStimulus(0, 1, 0, 2'd0); @(negedge clk);
      checkOutput("killdbl opcode", 32'(dOpcode), 32'd5);
      checkOutput("killdbl add_rd", 32'(addRd),   32'd0);

      // Enter the second phase, then stall two edges, then redirect.
      applyStimulus(0, 0, 0, 2'd3); @(negedge clk);
      applyStimulus(0, 0, 0, 2'd0); @(negedge clk);
      applyStimulus(1, 0, 0, 2'd0); @(negedge clk);
      @(negedge clk);
`ifdef IF_STAGE_DOUBLE_EN
      checkOutput("stall add_rd", 32'(addRd),   32'd1);
      checkOutput("stall opcode", 32'(dOpcode), 32'd7);
`else
      checkOutput("stall opcode", 32'(dOpcode), 32'd5);
`endif
      applyStimulus(0, 0, 0, 2'd1); @(negedge clk);
      checkOutput("abort opcode", 32'(dOpcode), 32'd5);
      checkOutput("abort add_rd", 32'(addRd),   32'd0);

      // Freeze the PC+1 buffer, then let it catch up under stall.
      applyStimulus(0, 0, 1, 2'd0); @(negedge clk);
      @(negedge clk);
      applyStimulus(1, 0, 0, 2'd0); @(negedge clk);
      @(negedge clk);

      // PC wrap and address wrap.
      jumpAddr = 32'hFFFF_FFFF;
      applyStimulus(0, 0, 0, 2'd3); @(negedge clk);
      checkOutput("top inst", instData, 32'h0);
      applyStimulus(0, 0, 0, 2'd0); @(negedge clk);
      checkOutput("wrap inst", instData,  32'h1444_0005);
      checkOutput("wrap pcbt", pcBuffTun, 32'h0);
      jumpAddr = 32'h0000_0101;
      applyStimulus(0, 0, 0, 2'd3); @(negedge clk);
      checkOutput("alias opcode", 32'(dOpcode), 32'd7);
      applyStimulus(0, 0, 0, 2'd0); @(negedge clk);

      // Asynchronous reset mid-run, checked between clock edges.
      #3; clear = 1'b0; #1;
      checkOutput("async inst",   instData,     32'h1444_0005);
      checkOutput("async opcode", 32'(dOpcode), 32'd5);
      checkOutput("async add_rd", 32'(addRd),   32'd0);
      checkOutput("async pcbt",   pcBuffTun,    32'h0);
      @(negedge clk); #1; clear = 1'b1;
      repeat (4) @(negedge clk);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

   // Guard against a stuck simulation.
   initial begin
      #100000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

endmodule
